// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one imem request at a
// time and registers the returned word for decode, flushing on branch redirects.
module fetch_ctrl #(
    parameter int unsigned           ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_data_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_valid_o
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                valid_q, valid_d;

    logic [ADDR_W-1:0]   branch_pc_c;
    logic [ADDR_W-1:0]   pc_inc_c;
    logic                slot_busy_c;

    assign branch_pc_c = branch_target_i & ~ADDR_W'(3);
    assign pc_inc_c    = fetch_pc_q + ADDR_W'(4);
    // The output slot cannot take a new word this cycle
    assign slot_busy_c = valid_q & stall_i;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        valid_d    = valid_q;

        // Held instruction is consumed whenever decode is not stalled
        if (valid_q && !stall_i) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                req_d   = 1'b1;
                addr_d  = fetch_pc_q;
                if (branch_i) begin
                    fetch_pc_d = branch_pc_c;
                    addr_d     = branch_pc_c;
                    valid_d    = 1'b0;
                end
            end

            S_REQ: begin
                if (branch_i) begin
                    fetch_pc_d = branch_pc_c;
                    valid_d    = 1'b0;
                    if (imem_ack_i) begin
                        addr_d = branch_pc_c;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (imem_ack_i) begin
                    if (slot_busy_c) begin
                        // Slot still stalled: drop the word, refetch it after release
                        state_d = S_HOLD;
                        req_d   = 1'b0;
                    end else begin
                        inst_d     = imem_data_i;
                        pc_d       = fetch_pc_q;
                        valid_d    = 1'b1;
                        fetch_pc_d = pc_inc_c;
                        addr_d     = pc_inc_c;
                    end
                end
            end

            S_HOLD: begin
                if (branch_i) begin
                    fetch_pc_d = branch_pc_c;
                    valid_d    = 1'b0;
                    state_d    = S_REQ;
                    req_d      = 1'b1;
                    addr_d     = branch_pc_c;
                end else if (!stall_i) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end

            S_DRAIN: begin
                if (branch_i) begin
                    fetch_pc_d = branch_pc_c;
                    valid_d    = 1'b0;
                    if (imem_ack_i) begin
                        state_d = S_REQ;
                        addr_d  = branch_pc_c;
                    end
                end else if (imem_ack_i) begin
                    state_d = S_REQ;
                    addr_d  = fetch_pc_q;
                end
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            inst_q     <= '0;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign inst_o       = inst_q;
    assign pc_o         = pc_q;
    assign inst_valid_o = valid_q;

endmodule
